// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus an iterative shift-add MUL.
// Results and flags are registered and held until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ai,
  input  logic [WIDTH-1:0] Bi,
  input  logic             Op2,
  input  logic             Op1,
  input  logic             Op0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Ri,
  output logic             Cout,
  output logic             Vout,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;
  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_MUL = 3'b011,
    OP_XOR = 3'b100, OP_NOR = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111
  } op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   ri_q, ri_d;
  logic               cout_q, cout_d;
  logic               vout_q, vout_d;
  logic               z_q, z_d;
  logic               ovalid_q, ovalid_d;

  op_e                op;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic               ovf;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_next;

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = ovalid_q;
  assign Ri        = ri_q;
  assign Cout      = cout_q;
  assign Vout      = vout_q;
  assign Z         = z_q;

  // Shared adder: ADD uses B, SUB/SLT use ~B with carry-in 1.
  always_comb begin
    op    = op_e'({Op2, Op1, Op0});
    b_eff = (op == OP_ADD) ? Bi : ~Bi;
    sum   = {1'b0, Ai} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op != OP_ADD)};
    ovf   = (Ai[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != Ai[WIDTH-1]);
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_AND: alu_r = Ai & Bi;
      OP_OR:  alu_r = Ai | Bi;
      OP_XOR: alu_r = Ai ^ Bi;
      OP_NOR: alu_r = ~(Ai | Bi);
      OP_ADD, OP_SUB: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = ovf;
      end
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ri_d     = ri_q;
    cout_d   = cout_q;
    vout_d   = vout_q;
    z_d      = z_q;
    ovalid_d = ovalid_q;
    acc_next = acc_q + (mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0);
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (op == OP_MUL) begin
            mcand_d  = Ai;
            mplier_d = Bi;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            ri_d     = alu_r;
            cout_d   = alu_c;
            vout_d   = alu_v;
            z_d      = (alu_r == '0);
            ovalid_d = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last partial product is folded in on the same edge the result is registered.
        if (cnt_q == CW'(WIDTH - 1)) begin
          ri_d     = acc_next[WIDTH-1:0];
          cout_d   = |acc_next[2*WIDTH-1:WIDTH];
          vout_d   = 1'b0;
          z_d      = (acc_next[WIDTH-1:0] == '0);
          ovalid_d = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ri_q     <= '0;
      cout_q   <= 1'b0;
      vout_q   <= 1'b0;
      z_q      <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ri_q     <= ri_d;
      cout_q   <= cout_d;
      vout_q   <= vout_d;
      z_q      <= z_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule
